// File: rtl/rat_pkg.sv
// ---------------------------------------------------------------------------
// rat_pkg : shared states, register selects, ctrl codes and hole table
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rat_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HIDDEN = 3'd1,
    RISE   = 3'd2,
    UP     = 3'd3,
    HIT    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    REG_BYPASS = 2'b00,
    REG_X0     = 2'b01,
    REG_Y0     = 2'b10,
    REG_CTRL   = 2'b11
  } reg_sel_e;

  localparam logic [4:0] CTRL_IDLE = 5'b00100;
  localparam logic [4:0] CTRL_RISE = 5'b00101;
  localparam logic [4:0] CTRL_UP   = 5'b00110;
  localparam logic [4:0] CTRL_HIT  = 5'b00111;

  localparam int RISE_FRAMES = 4;

  // Two rows of four holes.
  localparam logic [10:0] HOLE_X [8] = '{11'd160, 11'd400, 11'd640, 11'd880,
                                         11'd160, 11'd400, 11'd640, 11'd880};
  localparam logic [10:0] HOLE_Y [8] = '{11'd240, 11'd240, 11'd240, 11'd240,
                                         11'd520, 11'd520, 11'd520, 11'd520};

  function automatic logic [4:0] ctrl_of(state_e s);
    case (s)
      RISE:    ctrl_of = CTRL_RISE;
      UP:      ctrl_of = CTRL_UP;
      HIT:     ctrl_of = CTRL_HIT;
      default: ctrl_of = CTRL_IDLE;
    endcase
  endfunction

  // The sprite is shown (bypass off, real position) only in these states.
  function automatic logic visible_of(state_e s);
    visible_of = (s == RISE) || (s == UP) || (s == HIT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rat_reg_writer.sv
// ---------------------------------------------------------------------------
// rat_reg_writer : pending-flag register write sequencer for the sprite slot
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rat_reg_writer
  import rat_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [3:0]  set_i,
  input  logic        bypass_i,
  input  logic [10:0] x0_i,
  input  logic [10:0] y0_i,
  input  logic [4:0]  ctrl_i,
  output logic        cs_o,
  output logic        write_o,
  output logic [13:0] addr_o,
  output logic [31:0] wr_data_o
);

  logic [3:0]  pend_q, pend_d;
  logic [3:0]  avail, grant;
  reg_sel_e    sel;
  logic [31:0] data;
  logic        cs_q;
  logic [13:0] addr_q;
  logic [31:0] data_q;

  // Flags raised this cycle join the pending set so a re-set merges.
  always_comb begin
    avail = pend_q | set_i;
    grant = 4'b0000;
    sel   = REG_BYPASS;
    if (avail[0]) begin
      grant[0] = 1'b1;
      sel      = REG_BYPASS;
    end else if (avail[1]) begin
      grant[1] = 1'b1;
      sel      = REG_X0;
    end else if (avail[2]) begin
      grant[2] = 1'b1;
      sel      = REG_Y0;
    end else if (avail[3]) begin
      grant[3] = 1'b1;
      sel      = REG_CTRL;
    end
    pend_d = avail & ~grant;
    case (sel)
      REG_BYPASS: data = {31'd0, bypass_i};
      REG_X0:     data = {21'd0, x0_i};
      REG_Y0:     data = {21'd0, y0_i};
      default:    data = {27'd0, ctrl_i};
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= 4'b1111;
      cs_q   <= 1'b0;
      addr_q <= 14'd0;
      data_q <= 32'd0;
    end else begin
      pend_q <= pend_d;
      cs_q   <= |avail;
      addr_q <= (|avail) ? {1'b1, 11'd0, sel} : 14'd0;
      data_q <= (|avail) ? data : 32'd0;
    end
  end

  assign cs_o      = cs_q;
  assign write_o   = cs_q;
  assign addr_o    = addr_q;
  assign wr_data_o = data_q;

endmodule

`default_nettype wire

// File: rtl/rat_sprite_sched.sv
// ---------------------------------------------------------------------------
// rat_sprite_sched : whack-a-rat game sequencer driving the sprite slot regs
// rev 1.0 -- optional shrinking up-time via RAT_SPEEDUP_EN
// ---------------------------------------------------------------------------
`default_nettype none

module rat_sprite_sched
  import rat_pkg::*;
#(
  parameter int         N_HOLES    = 8,
  parameter int         HIT_FRAMES = 30,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic        start,
  input  logic        stop,
  input  logic        hit,
  input  logic [7:0]  up_frames,
  input  logic [7:0]  down_frames,
  output logic        spr_cs,
  output logic        spr_write,
  output logic [13:0] spr_addr,
  output logic [31:0] spr_wr_data,
  output logic [15:0] score,
  output logic [15:0] misses,
  output logic        rat_up,
  output logic        busy
);

  localparam int HW = (N_HOLES > 1) ? $clog2(N_HOLES) : 1;

  state_e          state_q, state_d;
  logic            zero_q, zero_d1_q, frame_tick, expire;
  logic [7:0]      cnt_q, cnt_d, lfsr_q, lfsr_d;
  logic [HW-1:0]   hole_q, hole_d;
  logic [15:0]     score_q, score_d, misses_q, misses_d;
  logic [7:0]      down_ld, up_raw, up_ld;
  logic [3:0]      set_mask;
  logic            vis_d;

  assign frame_tick = zero_q & ~zero_d1_q;
  assign expire     = frame_tick && (cnt_q == 8'd1);
  assign down_ld    = (down_frames == 8'd0) ? 8'd1 : down_frames;

`ifdef RAT_SPEEDUP_EN
  logic [2:0] hits_q;
  logic [3:0] offset_q;

  always_comb begin
    if (up_frames <= 8'd4 + {4'd0, offset_q}) up_raw = 8'd4;
    else                                      up_raw = up_frames - {4'd0, offset_q};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hits_q   <= 3'd0;
      offset_q <= 4'd0;
    end else if (!stop && state_q == IDLE && start) begin
      hits_q   <= 3'd0;
      offset_q <= 4'd0;
    end else if (!stop && state_q == UP && hit) begin
      hits_q <= hits_q + 3'd1;
      if (hits_q == 3'd7 && offset_q != 4'hF) offset_q <= offset_q + 4'd1;
    end
  end
`else
  assign up_raw = up_frames;
`endif

  assign up_ld = (up_raw == 8'd0) ? 8'd1 : up_raw;

  always_comb begin
    state_d  = state_q;
    cnt_d    = (frame_tick && cnt_q != 8'd0) ? cnt_q - 8'd1 : cnt_q;
    hole_d   = hole_q;
    score_d  = score_q;
    misses_d = misses_q;
    if (stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_d  = HIDDEN;
          score_d  = 16'd0;
          misses_d = 16'd0;
          cnt_d    = down_ld;
        end
        HIDDEN: if (expire) begin
          state_d = RISE;
          hole_d  = lfsr_q[HW-1:0];
          cnt_d   = 8'(RISE_FRAMES);
        end
        RISE: if (expire) begin
          state_d = UP;
          cnt_d   = up_ld;
        end
        // A hit landing on the expiry tick still counts as a hit.
        UP: if (hit) begin
          state_d = HIT;
          score_d = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
          cnt_d   = 8'(HIT_FRAMES);
        end else if (expire) begin
          state_d  = HIDDEN;
          misses_d = (misses_q == 16'hFFFF) ? misses_q : misses_q + 16'd1;
          cnt_d    = down_ld;
        end
        HIT: if (expire) begin
          state_d = HIDDEN;
          cnt_d   = down_ld;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Showing or hiding touches every register; otherwise only ctrl can move.
  always_comb begin
    set_mask = 4'b0000;
    if (visible_of(state_q) != visible_of(state_d))  set_mask = 4'b1111;
    else if (ctrl_of(state_q) != ctrl_of(state_d))   set_mask = 4'b1000;
  end

  assign lfsr_d = (state_q != IDLE)
                ? {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]}
                : lfsr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      zero_q    <= 1'b0;
      zero_d1_q <= 1'b0;
      cnt_q     <= 8'd0;
      lfsr_q    <= LFSR_SEED;
      hole_q    <= '0;
      score_q   <= 16'd0;
      misses_q  <= 16'd0;
    end else begin
      state_q   <= state_d;
      zero_q    <= (x == 11'd0) && (y == 11'd0);
      zero_d1_q <= zero_q;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      hole_q    <= hole_d;
      score_q   <= score_d;
      misses_q  <= misses_d;
    end
  end

  assign vis_d = visible_of(state_d);

  rat_reg_writer u_writer (
    .clk_i     (clk),
    .rst_ni    (reset),
    .set_i     (set_mask),
    .bypass_i  (~vis_d),
    .x0_i      (vis_d ? HOLE_X[hole_d] : 11'd0),
    .y0_i      (vis_d ? HOLE_Y[hole_d] : 11'd0),
    .ctrl_i    (ctrl_of(state_d)),
    .cs_o      (spr_cs),
    .write_o   (spr_write),
    .addr_o    (spr_addr),
    .wr_data_o (spr_wr_data)
  );

  assign score  = score_q;
  assign misses = misses_q;
  assign rat_up = (state_q == RISE) || (state_q == UP);
  assign busy   = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_rat_sprite_sched.sv
// ---------------------------------------------------------------------------
// tb_rat_sprite_sched : directed self-checking bench for rat_sprite_sched
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rat_sprite_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [10:0] x = 11'd1, y = 11'd1;
  logic        start = 1'b0, stop = 1'b0, hit = 1'b0;
  logic [7:0]  up_frames = 8'd3, down_frames = 8'd2;
  logic        spr_cs, spr_write, rat_up, busy;
  logic [13:0] spr_addr;
  logic [31:0] spr_wr_data;
  logic [15:0] score, misses;

  int n_chk  = 0;
  int n_pass = 0;

  logic [13:0] addr_log [$];
  logic [31:0] data_log [$];

  int tx [8] = '{160, 400, 640, 880, 160, 400, 640, 880};
  int ty [8] = '{240, 240, 240, 240, 520, 520, 520, 520};

  rat_sprite_sched dut (
    .clk         (clk),
    .reset       (reset),
    .x           (x),
    .y           (y),
    .start       (start),
    .stop        (stop),
    .hit         (hit),
    .up_frames   (up_frames),
    .down_frames (down_frames),
    .spr_cs      (spr_cs),
    .spr_write   (spr_write),
    .spr_addr    (spr_addr),
    .spr_wr_data (spr_wr_data),
    .score       (score),
    .misses      (misses),
    .rat_up      (rat_up),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (spr_cs) begin
      addr_log.push_back(spr_addr);
      data_log.push_back(spr_wr_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic check_wr(input string tag, input int idx, input logic [13:0] a, input logic [31:0] d);
    logic [13:0] ga;
    logic [31:0] gd;
    ga = (idx < addr_log.size()) ? addr_log[idx] : 14'bx;
    gd = (idx < data_log.size()) ? data_log[idx] : 32'bx;
    check({tag, "_addr"}, {18'd0, ga}, {18'd0, a});
    check({tag, "_data"}, gd, d);
  endtask

  task automatic clear_log();
    addr_log.delete();
    data_log.delete();
  endtask

  task automatic do_tick();
    x = 11'd0; y = 11'd0;
    @(negedge clk);
    x = 11'd1; y = 11'd1;
    repeat (6) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic pulse(input logic do_start, input logic do_stop, input logic do_hit);
    start = do_start; stop = do_stop; hit = do_hit;
    @(negedge clk);
    start = 1'b0; stop = 1'b0; hit = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_idle_burst(input string tag);
    check({tag, "_n"}, addr_log.size(), 4);
    check_wr({tag, "_byp"},  0, 14'h2000, 32'd1);
    check_wr({tag, "_x0"},   1, 14'h2001, 32'd0);
    check_wr({tag, "_y0"},   2, 14'h2002, 32'd0);
    check_wr({tag, "_ctrl"}, 3, 14'h2003, 32'd4);
  endtask

  initial begin
    int found;

    // Reset state and the power-up burst
    repeat (3) @(negedge clk);
    check("rst_cs", spr_cs, 0);
    check("rst_addr", spr_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_score", score, 0);
    reset = 1'b1;
    @(negedge clk);
    check("boot_we", spr_write, 1);
    repeat (3) @(negedge clk);
    #1;
    check_idle_burst("boot");
    repeat (3) @(negedge clk);
    check("boot_quiet", spr_cs, 0);
    check("boot_nwr", addr_log.size(), 4);

    // Start, miss path with down=2, up=3
    clear_log();
    down_frames = 8'd2; up_frames = 8'd3;
    pulse(1, 0, 0);
    check("start_busy", busy, 1);
    check("start_nowr", addr_log.size(), 0);
    do_tick();
    check("hid1_up", rat_up, 0);
    do_tick();
    check("rise_up", rat_up, 1);
    check("rise_n", addr_log.size(), 4);
    check_wr("rise_byp", 0, 14'h2000, 32'd0);
    check_wr("rise_ctrl", 3, 14'h2003, 32'd5);
    found = 0;
    for (int h = 0; h < 8; h++)
      if (addr_log.size() == 4 && data_log[1] == tx[h] && data_log[2] == ty[h]) found = 1;
    check("rise_holexy", found, 1);
    clear_log();
    ticks(4);
    check("up_n", addr_log.size(), 1);
    check_wr("up_ctrl", 0, 14'h2003, 32'd6);
    ticks(2);
    check("up2_miss", misses, 0);
    clear_log();
    do_tick();
    check("miss_cnt", misses, 1);
    check("miss_up", rat_up, 0);
    check_idle_burst("miss");

    // Hits outside UP are ignored; hit in UP scores
    clear_log();
    pulse(0, 0, 1);
    check("hid_hit_score", score, 0);
    check("hid_hit_nowr", addr_log.size(), 0);
    ticks(2);
    clear_log();
    pulse(0, 0, 1);
    check("rise_hit_score", score, 0);
    check("rise_hit_nowr", addr_log.size(), 0);
    ticks(4);
    clear_log();
    pulse(0, 0, 1);
    check("hit_score", score, 1);
    check("hit_n", addr_log.size(), 1);
    check_wr("hit_ctrl", 0, 14'h2003, 32'd7);
    clear_log();
    ticks(29);
    check("hit29_nowr", addr_log.size(), 0);
    do_tick();
    check("hit30_busy", busy, 1);
    check("hit30_up", rat_up, 0);
    check_wr("hit30_byp", 0, 14'h2000, 32'd1);
    ticks(2);
    check("hid_to_rise", rat_up, 1);

    // stop beats hit in UP
    ticks(4);
    clear_log();
    pulse(0, 1, 1);
    check("stop_busy", busy, 0);
    check("stop_score", score, 1);
    check_idle_burst("stop");

    // Zero durations behave as one tick
    down_frames = 8'd0; up_frames = 8'd0;
    pulse(1, 0, 0);
    check("restart_score", score, 0);
    check("restart_miss", misses, 0);
    do_tick();
    check("down0_rise", rat_up, 1);
    ticks(4);
    check("up0_up", rat_up, 1);
    do_tick();
    check("up0_gone", rat_up, 0);
    check("up0_miss", misses, 1);

    // Score saturation
    ticks(5);
    force dut.score_q = 16'hFFFE;
    @(negedge clk);
    release dut.score_q;
    pulse(0, 0, 1);
    check("sat1", score, 16'hFFFF);
    ticks(31);
    ticks(4);
    check("sat_up", rat_up, 1);
    pulse(0, 0, 1);
    check("sat2", score, 16'hFFFF);

    // Reset in the middle of a burst
    clear_log();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
    #2;
    check("mid_n", addr_log.size(), 2);
    reset = 1'b0;
    #1;
    check("mid_cs", spr_cs, 0);
    check("mid_addr", spr_addr, 0);
    check("mid_data", spr_wr_data, 0);
    check("mid_score", score, 0);
    repeat (2) @(negedge clk);
    clear_log();
    reset = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check_idle_burst("rerst");
    check("rerst_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rat_sprite_sched.md
Name: rat_sprite_sched

Overview:
- Game-level sequencer for the rat sprite core.
- Picks a random hole, pops the rat up for a programmable number of frames, then detects a hammer hit or a miss.
- Drives the sprite core's video-slot write interface (bypass, x0, y0, ctrl registers) through a single write port.
- Sits between the game top level / hammer logic and the sprite core, on the same clk and the same frame counter.

Parameters:
- N_HOLES, 8, number of hole positions (power of 2); coordinates come from package tables.
- HIT_FRAMES, 30, frames the hit animation is shown before the rat hides.
- LFSR_SEED, 8'hA5, non-zero reset seed of the 8-bit hole-select LFSR.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- x  in  11  frame counter x.
- y  in  11  frame counter y.
- start  in  1  one-cycle pulse: begin game.
- stop  in  1  one-cycle pulse: end game.
- hit  in  1  one-cycle pulse: hammer struck the rat area.
- up_frames  in  8  frames the rat stays up.
- down_frames  in  8  frames the rat stays hidden.
- spr_cs  out  1  sprite slot chip select.
- spr_write  out  1  sprite slot write strobe.
- spr_addr  out  14  sprite slot address.
- spr_wr_data  out  32  sprite slot write data.
- score  out  16  hits counted (saturating).
- misses  out  16  timeouts counted (saturating).
- rat_up  out  1  high in RISE and UP states.
- busy  out  1  high when not IDLE.

Behaviour:
- Frame tick: `frame_tick` pulses for one cycle on the rising edge of (x==0 && y==0), using a registered compare. All durations are counted in frame ticks.
- States and transitions:
  - IDLE: on start, go to HIDDEN, clear score and misses, load down counter.
  - HIDDEN: when the down counter expires, latch hole = lfsr[log2(N_HOLES)-1:0], go to RISE.
  - RISE: lasts 4 frames (ctrl = CTRL_RISE), then go to UP and load up counter.
  - UP: ctrl = CTRL_UP.
    - hit → score++, go to HIT.
    - Up counter expires → misses++, go to HIDDEN.
  - HIT: ctrl = CTRL_HIT for HIT_FRAMES frames, then go to HIDDEN.
- Stop in any state → IDLE. Stop has priority over start, hit, and timeouts in the same cycle.
- hit outside UP is ignored. hit coincident with UP expiry counts as a hit.
- Counter loads:
  - up_frames and down_frames are sampled when their counter is loaded.
  - A value of 0 is treated as 1.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Advances every clk while busy.
- Saturation: score and misses hold at 16'hFFFF.
- Register-write sequencer:
  - Four pending flags: bypass, x0, y0, ctrl.
  - Every state entry sets the flags that entry changes. Reset sets all four.
  - Exactly one write per cycle, priority bypass > x0 > y0 > ctrl: spr_cs=1, spr_write=1, spr_addr = {1'b1, 11'b0, sel[1:0]}.
  - sel encoding: 00 bypass, 01 x0, 10 y0, 11 ctrl.
  - Data is computed at issue time from the current state and hole, zero-extended.
  - Bypass = 1 in IDLE and HIDDEN, 0 otherwise.
  - First write occurs the cycle after the entry edge; a full update completes within 4 cycles.
  - A re-set of a still-pending flag merges; the latest value is written.
  - spr_cs, spr_write, spr_addr and spr_wr_data are all 0 when idle.
  - spr_addr[13]=0 (sprite RAM) is never generated.
- Reset values: state IDLE, all outputs 0, lfsr = LFSR_SEED, all pending flags 1.
  - First cycles after reset release write bypass=1, x0=0, y0=0, ctrl=CTRL_IDLE.
- Reset mid-operation: immediate return to reset values; any in-flight write is abandoned.

Optional Feature:
- RAT_SPEEDUP_EN defined:
  - A 3-bit hit counter tracks hits.
  - Every 8th hit raises a speed offset by 1, capped at 15.
  - Effective up time = max(up_frames − offset, 4).
  - Offset clears on start.
- RAT_SPEEDUP_EN not defined: effective up time = up_frames; the offset and its counter are absent.

Decomposition:
- Package rat_pkg holds:
  - State enum: IDLE, HIDDEN, RISE, UP, HIT.
  - Register selects: REG_BYPASS, REG_X0, REG_Y0, REG_CTRL.
  - ctrl constants, all 5-bit: CTRL_IDLE=5'b00100, CTRL_RISE, CTRL_UP, CTRL_HIT.
  - HOLE_X and HOLE_Y constant arrays (11-bit each), RISE_FRAMES=4.
- One sub-module, rat_reg_writer: owns the pending flags, the priority pick, and the bus outputs. Inputs: set mask plus current values.

Test Plan:
- Release reset → 4 consecutive writes to addr 0x2000, 0x2001, 0x2002, 0x2003 with data 1, 0, 0, 5'b00100; then bus idle; busy=0.
- start, down_frames=2, up_frames=3, no hit → after 2 ticks, writes for x0/y0 of the chosen hole plus bypass=0 and ctrl=CTRL_RISE. After 4+3 more ticks, misses=1 and bypass=1 is written.
- hit pulsed during UP → score=1, ctrl=CTRL_HIT written; after 30 ticks bypass=1 is written and state is HIDDEN.
- hit during HIDDEN or RISE → score unchanged, no writes. stop and hit in the same cycle in UP → IDLE, score unchanged.
- Force score=16'hFFFE, then two hits → score=16'hFFFF. up_frames=0 → rat stays up exactly 1 tick.
- Assert reset mid-burst (after the second write) → bus 0 immediately; after release, a full 4-write burst repeats.
